alu_seq_n: RTL and testbench

- Parametrised, registered ALU: next generation of the team's 4-bit combinational ALU.
- Adds N-bit width, a start/busy/done handshake, registered result and flags (C, Z, N, V), and real multi-bit shift/rotate.
- Shift/rotate is iterative by default, one bit per cycle. It is used as the datapath execution unit under the lab CPU controller.

---
 rtl/alu_seq_n.sv | 199 +++++++++++++++++++
 tb/tb_alu_seq_n.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_n.sv
// Registered N-bit ALU with start/busy/done handshake and iterative shift/rotate.
// Define ALU_SEQ_BARREL_EN to build single-cycle shifts/rotates instead.
module alu_seq_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Control,
    input  logic             Cin,
    output logic [WIDTH-1:0] ALU_output,
    output logic             Cout,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned WP1 = WIDTH + 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_ROL = 3'b110,
        OP_ROR = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    // One 1-bit shift/rotate step; returns {bit moved out, new value}.
    function automatic logic [WIDTH:0] step1(input op_e op, input logic [WIDTH-1:0] v);
        logic [WIDTH:0] r;
        r = {1'b0, v};
        case (op)
            OP_SHL:  r = {v, 1'b0};
            OP_SHR:  r = {v[0], 1'b0, v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

`ifdef ALU_SEQ_BARREL_EN
    // Cascade of conditional 1-bit stages, so Cout matches the iterative build exactly.
    function automatic logic [WIDTH:0] barrel(input op_e op, input logic [WIDTH-1:0] v,
                                              input logic [SHW-1:0] k);
        logic [WIDTH:0] r;
        r = {1'b0, v};
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
            if (i < 32'(k)) r = step1(op, r[WIDTH-1:0]);
        end
        return r;
    endfunction
`endif

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] res_d;
    logic             cout_d, zero_d, neg_d, ovf_d, busy_d, done_d;

    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   add_sum, sub_sum, step_r;
    logic             add_ovf, sub_ovf, launch;
    logic [WIDTH-1:0] ex_res;
    logic             ex_cout, ex_ovf;

    assign amt     = B[SHW-1:0];
    assign add_sum = {1'b0, A} + {1'b0, B} + WP1'(Cin);
    assign sub_sum = {1'b0, A} + {1'b0, ~B} + WP1'(1);
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
    assign step_r  = step1(op_q, work_q);

`ifdef ALU_SEQ_BARREL_EN
    assign launch = 1'b0;
`else
    assign launch = Control[2] && (amt != '0);
`endif

    // Single-cycle result for everything that does not enter SHIFT.
    always_comb begin
        ex_res  = '0;
        ex_cout = 1'b0;
        ex_ovf  = 1'b0;
        case (op_e'(Control))
            OP_ADD: begin
                {ex_cout, ex_res} = add_sum;
                ex_ovf            = add_ovf;
            end
            OP_SUB: begin
                {ex_cout, ex_res} = sub_sum;
                ex_ovf            = sub_ovf;
            end
            OP_OR:  ex_res = A | B;
            OP_AND: ex_res = A & B;
            default: begin
`ifdef ALU_SEQ_BARREL_EN
                {ex_cout, ex_res} = barrel(op_e'(Control), A, amt);
`else
                ex_res = A;
`endif
            end
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        res_d   = ALU_output;
        cout_d  = Cout;
        zero_d  = Zero;
        neg_d   = Neg;
        ovf_d   = Ovf;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = op_e'(Control);
                    if (launch) begin
                        work_d  = A;
                        cnt_d   = amt;
                        busy_d  = 1'b1;
                        state_d = S_SHIFT;
                    end else begin
                        res_d  = ex_res;
                        cout_d = ex_cout;
                        ovf_d  = ex_ovf;
                        zero_d = (ex_res == '0);
                        neg_d  = ex_res[WIDTH-1];
                        done_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                work_d = step_r[WIDTH-1:0];
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    res_d   = step_r[WIDTH-1:0];
                    cout_d  = step_r[WIDTH];
                    ovf_d   = 1'b0;
                    zero_d  = (step_r[WIDTH-1:0] == '0);
                    neg_d   = step_r[WIDTH-1];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            work_q     <= '0;
            cnt_q      <= '0;
            ALU_output <= '0;
            Cout       <= 1'b0;
            Zero       <= 1'b0;
            Neg        <= 1'b0;
            Ovf        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ALU_output <= res_d;
            Cout       <= cout_d;
            Zero       <= zero_d;
            Neg        <= neg_d;
            Ovf        <= ovf_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_n.sv
// Scoreboard bench for alu_seq_n (WIDTH=8); follows ALU_SEQ_BARREL_EN for timing expectations.
module tb_alu_seq_n;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, OR_ = 3'b010, AND_ = 3'b011;
    localparam logic [2:0] SHL = 3'b100, SHR = 3'b101, ROL = 3'b110, ROR = 3'b111;

    logic       clk = 1'b0;
    logic       rst, start, cin;
    logic [7:0] a, b, y;
    logic [2:0] ctrl;
    logic       cout, zero, neg, ovf, busy, done;

    always #5 clk = ~clk;

    alu_seq_n #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Control(ctrl), .Cin(cin),
        .ALU_output(y), .Cout(cout), .Zero(zero), .Neg(neg), .Ovf(ovf),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       v;
        int         lat;
        int         bsy;
        int         s;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0, cyc = 0, busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic int lat_of(int k);
`ifdef ALU_SEQ_BARREL_EN
        return 1 + 0 * k;
`else
        return k + 1;
`endif
    endfunction

    function automatic int busy_of(int k);
`ifdef ALU_SEQ_BARREL_EN
        return 0 * k;
`else
        return k;
`endif
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no done (y=%0h)", y);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, "_res"}, int'(y), int'(e.res));
                    chk({e.nm, "_cout"}, int'(cout), int'(e.c));
                    chk({e.nm, "_zero"}, int'(zero), int'(e.res == 8'h00));
                    chk({e.nm, "_neg"}, int'(neg), int'(e.res[7]));
                    chk({e.nm, "_ovf"}, int'(ovf), int'(e.v));
                    chk({e.nm, "_lat"}, cyc - e.s + 1, e.lat);
                    chk({e.nm, "_busycyc"}, busy_run, e.bsy);
                    chk({e.nm, "_busy_at_done"}, int'(busy), 0);
                end
                busy_run = 0;
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] op, input logic [7:0] ia,
                         input logic [7:0] ib, input logic ic, input logic [7:0] er,
                         input logic ec, input logic ev, input int k, input bit push);
        exp_t e;
        ctrl  = op;
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        if (push) begin
            e.res = er;
            e.c   = ec;
            e.v   = ev;
            e.lat = lat_of(k);
            e.bsy = busy_of(k);
            e.s   = cyc + 1;
            e.nm  = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL timeout: got %0d pending after 40 cycles expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_cout"}, int'(cout), 0);
        chk({tag, "_zero"}, int'(zero), 0);
        chk({tag, "_neg"}, int'(neg), 0);
        chk({tag, "_ovf"}, int'(ovf), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int  n;
        bit  ign_push;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; ctrl = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back latency-1 ops.
        issue("add_ff_01", ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1);
        issue("add_7f_01", ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1);
        issue("sub_05_07", SUB, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0, 1);
        issue("sub_80_01", SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 0, 1);
        issue("sub_05_05", SUB, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1);
        issue("add_cin",   ADD, 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0, 0, 1);
        issue("or_a0_05",  OR_, 8'hA0, 8'h05, 1'b1, 8'hA5, 1'b0, 1'b0, 0, 1);
        wait_idle();

        issue("rol_81_3",  ROL, 8'h81, 8'h03, 1'b0, 8'h0C, 1'b0, 1'b0, 3, 1);
        wait_idle();
        issue("shr_80_0",  SHR, 8'h80, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 0, 1);
        wait_idle();
        issue("ror_01_1",  ROR, 8'h01, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0, 1, 1);
        wait_idle();
        issue("shr_81_1",  SHR, 8'h81, 8'h01, 1'b0, 8'h40, 1'b1, 1'b0, 1, 1);
        wait_idle();
        issue("shl_c0_2",  SHL, 8'hC0, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0, 2, 1);
        wait_idle();
        issue("ror_f0_5",  ROR, 8'hF0, 8'h05, 1'b0, 8'h87, 1'b1, 1'b0, 5, 1);
        wait_idle();

        // Start during busy is dropped; a start on the done cycle is taken.
`ifdef ALU_SEQ_BARREL_EN
        ign_push = 1'b1;
`else
        ign_push = 1'b0;
`endif
        issue("shl_01_7",  SHL, 8'h01, 8'h07, 1'b0, 8'h80, 1'b0, 1'b0, 7, 1);
        issue("add_busy",  ADD, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 0, ign_push);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait_bound", int'(n < 20), 1);
        issue("add_b2b",   ADD, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 0, 1);
        wait_idle();

        // Reset in the middle of a shift: nothing should complete afterwards.
        issue("ror_rst",   ROR, 8'hF0, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 5, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("midrst");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        issue("and_f0_3c", AND_, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 0, 1);
        wait_idle();
        chk("sb_empty", sb.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
